opcode_sequencer: RTL and testbench

Parametrised successor to the single-opcode latch at the top level. Stores a short program of control words entered one at a time with the debounced start button. Replays the program into the Datapath, either free-running one word per clock or one word per step pulse. Its output replaces the latched OPcode register. Empty cycles present an all-zero control word, so RW is 0 and nothing is written.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_mem.sv | 25 ++
 rtl/opcode_sequencer.sv | 171 +++++++++++++++++
 tb/tb_opcode_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and control-word field layout for the opcode sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Datapath control-word packing (16-bit word)
    localparam int unsigned CW_DA_MSB = 15;
    localparam int unsigned CW_DA_LSB = 13;
    localparam int unsigned CW_AA_MSB = 12;
    localparam int unsigned CW_AA_LSB = 10;
    localparam int unsigned CW_BA_MSB = 9;
    localparam int unsigned CW_BA_LSB = 7;
    localparam int unsigned CW_MB_BIT = 6;
    localparam int unsigned CW_FS_MSB = 5;
    localparam int unsigned CW_FS_LSB = 2;
    localparam int unsigned CW_MD_BIT = 1;
    localparam int unsigned CW_RW_BIT = 0;

    localparam logic [15:0] CW_NOP = '0;

    function automatic logic cw_writes(input logic [15:0] cw);
        return cw[CW_RW_BIT];
    endfunction

endpackage

// File: rtl/seq_mem.sv
// Program buffer: DEPTH x CW_W register file, synchronous write, combinational read.
module seq_mem #(
    parameter int unsigned CW_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [CW_W-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [CW_W-1:0] o_rdata
);

    logic [CW_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/opcode_sequencer.sv
// Stores a short control-word program and replays it free-running or per step.
// Optional macro SEQ_LOOP_EN: RUN wraps continuously until stopped by a run pulse.
module opcode_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned CW_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            load,
    input  logic [CW_W-1:0] opcode_in,
    input  logic            run,
    input  logic            step,
    input  logic            clear,
    output logic [CW_W-1:0] cw_out,
    output logic            cw_valid,
    output logic [AW-1:0]   pc,
    output logic [AW:0]     count,
    output logic            full,
    output logic            empty,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int unsigned CNT_W = AW + 1;

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   w_pc_nxt;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_nxt;
    logic [CW_W-1:0] r_cw;
    logic [CW_W-1:0] w_cw_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_overflow;
    logic            w_overflow_nxt;
    logic            w_we;
    logic            w_issue;
    logic            w_last;
    logic            w_full;
    logic            w_empty;
    logic [CW_W-1:0] w_rdata;

    seq_mem #(
        .CW_W (CW_W),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_count[AW-1:0]),
        .i_wdata(opcode_in),
        .i_raddr(r_pc),
        .o_rdata(w_rdata)
    );

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_last  = ((CNT_W'(r_pc) + CNT_W'(1)) == r_count);

    // Only the highest-priority pulse is considered; if it is ignored, lower ones are too.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_count_nxt    = r_count;
        w_cw_nxt       = CW_W'(CW_NOP);
        w_valid_nxt    = 1'b0;
        w_overflow_nxt = r_overflow;
        w_we           = 1'b0;
        w_issue        = 1'b0;

        if (clear) begin
            w_state_nxt    = ST_IDLE;
            w_pc_nxt       = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        if (!w_empty) begin
                            w_pc_nxt    = '0;
                            w_state_nxt = ST_RUN;
                        end
                    end else if (step) begin
                        w_issue = !w_empty;
                    end else if (load) begin
                        if (w_full) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_we        = 1'b1;
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
`ifdef SEQ_LOOP_EN
                    if (run) begin
                        w_pc_nxt    = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_issue = 1'b1;
                    end
`else
                    w_issue = 1'b1;
`endif
                end
                ST_DONE: begin
                    if (run && !w_empty) begin
                        w_pc_nxt    = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_issue) begin
                w_cw_nxt    = w_rdata;
                w_valid_nxt = 1'b1;
                if (w_last) begin
                    w_pc_nxt = '0;
`ifdef SEQ_LOOP_EN
                    if (r_state != ST_RUN) begin
                        w_state_nxt = ST_DONE;
                    end
`else
                    w_state_nxt = ST_DONE;
`endif
                end else begin
                    w_pc_nxt = r_pc + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_count    <= '0;
            r_cw       <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_count    <= w_count_nxt;
            r_cw       <= w_cw_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign cw_out   = r_cw;
    assign cw_valid = r_valid;
    assign pc       = r_pc;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Self-checking bench for opcode_sequencer: vector table, corner sequences, random vs model.
module tb_opcode_sequencer;

    localparam int unsigned CW_W  = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic            clk = 1'b0;
    logic            reset_b = 1'b0;
    logic            load = 1'b0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            clear = 1'b0;
    logic [CW_W-1:0] opcode_in = '0;
    logic [CW_W-1:0] cw_out;
    logic            cw_valid;
    logic [AW-1:0]   pc;
    logic [AW:0]     count;
    logic            full, empty, busy, done, overflow;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    opcode_sequencer #(.CW_W(CW_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_b(reset_b), .load(load), .opcode_in(opcode_in),
        .run(run), .step(step), .clear(clear), .cw_out(cw_out),
        .cw_valid(cw_valid), .pc(pc), .count(count), .full(full),
        .empty(empty), .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct packed {
        logic        c, r, s, l;
        logic [15:0] d;
        logic [28:0] exp;
    } vec_t;

    function automatic logic [28:0] snap();
        return {cw_out, cw_valid, pc, count, full, empty, busy, done, overflow};
    endfunction

    function automatic logic [28:0] ex(input logic [15:0] cw, input logic v, input logic [2:0] p,
                                       input logic [3:0] c, input logic b, input logic dn,
                                       input logic o);
        return {cw, v, p, c, (c == 4'd8), (c == 4'd0), b, dn, o};
    endfunction

    function automatic vec_t mkv(input logic c, input logic r, input logic s, input logic l,
                                 input logic [15:0] d, input logic [28:0] e);
        vec_t v;
        v.c = c; v.r = r; v.s = s; v.l = l; v.d = d; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive one set of pulses, let one rising edge sample them, return 1 time unit later.
    task automatic pulse(input logic c, input logic r, input logic s, input logic l,
                         input logic [15:0] d);
        clear = c; run = r; step = s; load = l; opcode_in = d;
        @(posedge clk);
        #1;
        clear = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    vec_t tbl[12];

    // Reference model state: program contents, words still to be replayed, flags.
    logic [15:0] m_prog[$];
    logic [15:0] m_pend[$];
    int          m_pc;
    bit          m_done, m_ovf;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(0, 0, 0, 1, 16'hA001, ex(16'h0,    0, 0, 1, 0, 0, 0));
        tbl[1]  = mkv(0, 0, 0, 1, 16'h2403, ex(16'h0,    0, 0, 2, 0, 0, 0));
        tbl[2]  = mkv(0, 0, 0, 1, 16'h0000, ex(16'h0,    0, 0, 3, 0, 0, 0));
        tbl[3]  = mkv(0, 1, 0, 0, 16'h0,    ex(16'h0,    0, 0, 3, 1, 0, 0));
        tbl[4]  = mkv(0, 0, 0, 0, 16'h0,    ex(16'hA001, 1, 1, 3, 1, 0, 0));
        tbl[5]  = mkv(0, 0, 0, 0, 16'h0,    ex(16'h2403, 1, 2, 3, 1, 0, 0));
        tbl[6]  = mkv(0, 0, 0, 0, 16'h0,    ex(16'h0000, 1, 0, 3, 0, 1, 0));
        tbl[7]  = mkv(0, 0, 0, 0, 16'h0,    ex(16'h0,    0, 0, 3, 0, 1, 0));
        tbl[8]  = mkv(0, 1, 0, 1, 16'h5555, ex(16'h0,    0, 0, 3, 1, 0, 0));
        tbl[9]  = mkv(0, 0, 0, 0, 16'h0,    ex(16'hA001, 1, 1, 3, 1, 0, 0));
        tbl[10] = mkv(1, 1, 0, 0, 16'h0,    ex(16'h0,    0, 0, 0, 0, 0, 0));
        tbl[11] = mkv(0, 1, 0, 0, 16'h0,    ex(16'h0,    0, 0, 0, 0, 0, 0));

        #12;
        chk("reset", 32'(snap()), 32'(ex(16'h0, 0, 0, 0, 0, 0, 0)));
        reset_b = 1'b1;

        for (int i = 0; i < 12; i++) begin
            pulse(tbl[i].c, tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].d);
            chk($sformatf("vec%0d", i), 32'(snap()), 32'(tbl[i].exp));
        end

        // Fill to DEPTH, overflow, then confirm entry 7 survived by replaying it.
        for (int i = 0; i < 8; i++) pulse(0, 0, 0, 1, 16'h1000 + 16'(i));
        chk("fill_full", 32'(snap()), 32'(ex(16'h0, 0, 0, 8, 0, 0, 0)));
        pulse(0, 0, 0, 1, 16'hDEAD);
        chk("overflow", 32'(snap()), 32'(ex(16'h0, 0, 0, 8, 0, 0, 1)));
        pulse(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            chk($sformatf("replay%0d", i), 32'(snap()),
                32'(ex(16'h1000 + 16'(i), 1, 3'((i + 1) % 8), 8, (i < 7), (i == 7), 1)));
        end
        pulse(1, 0, 0, 0, 16'h0);
        chk("clear_ovf", 32'(snap()), 32'(ex(16'h0, 0, 0, 0, 0, 0, 0)));

        // run and load on the same edge in IDLE: run wins, nothing appended
        pulse(0, 0, 0, 1, 16'h1111);
        pulse(0, 0, 0, 1, 16'h2222);
        pulse(0, 1, 0, 1, 16'h3333);
        chk("run_load", 32'(snap()), 32'(ex(16'h0, 0, 0, 2, 1, 0, 0)));
        idle(1);
        chk("run_w0", 32'(snap()), 32'(ex(16'h1111, 1, 1, 2, 1, 0, 0)));
        idle(1);
        chk("run_w1", 32'(snap()), 32'(ex(16'h2222, 1, 0, 2, 0, 1, 0)));

        // single-step sequence
        pulse(1, 0, 0, 0, 16'h0);
        pulse(0, 0, 0, 1, 16'h1111);
        pulse(0, 0, 0, 1, 16'h2222);
        pulse(0, 0, 1, 0, 16'h0);
        chk("step0", 32'(snap()), 32'(ex(16'h1111, 1, 1, 2, 0, 0, 0)));
        idle(1);
        chk("step_gap", 32'(snap()), 32'(ex(16'h0, 0, 1, 2, 0, 0, 0)));
        idle(4);
        pulse(0, 0, 1, 0, 16'h0);
        chk("step1", 32'(snap()), 32'(ex(16'h2222, 1, 0, 2, 0, 1, 0)));
        pulse(0, 0, 1, 1, 16'h4444);
        chk("done_ign", 32'(snap()), 32'(ex(16'h0, 0, 0, 2, 0, 1, 0)));

        // asynchronous reset mid-RUN, checked between clock edges
        pulse(0, 1, 0, 0, 16'h0);
        idle(1);
        chk("mid_run", 32'(snap()), 32'(ex(16'h1111, 1, 1, 2, 1, 0, 0)));
        #2 reset_b = 1'b0;
        #1 chk("async_rst", 32'(snap()), 32'(ex(16'h0, 0, 0, 0, 0, 0, 0)));
        #1 reset_b = 1'b1;
        pulse(0, 1, 0, 0, 16'h0);
        chk("run_empty", 32'(snap()), 32'(ex(16'h0, 0, 0, 0, 0, 0, 0)));

`ifdef SEQ_LOOP_EN
        pulse(0, 0, 0, 1, 16'h0A0A);
        pulse(0, 0, 0, 1, 16'h0B0B);
        pulse(0, 0, 0, 1, 16'h0C0C);
        pulse(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk($sformatf("loop%0d", i), 32'({cw_out, cw_valid, busy}),
                32'({16'h0A0A + 16'h0101 * 16'(i % 3), 1'b1, 1'b1}));
        end
        pulse(0, 1, 0, 0, 16'h0);
        chk("loop_stop", 32'({cw_valid, busy, done}), 32'(3'b001));
`else
        // run while RUN is ignored; replay continues
        pulse(0, 0, 0, 1, 16'h0A0A);
        pulse(0, 0, 0, 1, 16'h0B0B);
        pulse(0, 1, 0, 0, 16'h0);
        pulse(0, 1, 1, 0, 16'h0);
        chk("run_in_run", 32'(snap()), 32'(ex(16'h0A0A, 1, 1, 2, 1, 0, 0)));
        idle(1);
        chk("run_in_run2", 32'(snap()), 32'(ex(16'h0B0B, 1, 0, 2, 0, 1, 0)));

        // randomized traffic against the queue-based model
        pulse(1, 0, 0, 0, 16'h0);
        m_prog.delete(); m_pend.delete(); m_pc = 0; m_done = 0; m_ovf = 0;
        for (int it = 0; it < 600; it++) begin
            logic        c, r, s, l, mv;
            logic [15:0] d, mcw;
            c = ($urandom_range(99) < 2);
            r = ($urandom_range(99) < 6);
            s = ($urandom_range(99) < 12);
            l = ($urandom_range(99) < 40);
            d = 16'($urandom);
            mcw = 16'h0; mv = 1'b0;
            if (c) begin
                m_prog.delete(); m_pend.delete(); m_pc = 0; m_done = 0; m_ovf = 0;
            end else if (m_pend.size() > 0) begin
                mcw = m_pend.pop_front(); mv = 1'b1;
                if (m_pend.size() == 0) begin
                    m_done = 1; m_pc = 0;
                end else begin
                    m_pc = m_prog.size() - m_pend.size();
                end
            end else if (r) begin
                if (m_prog.size() > 0) begin
                    m_pend = m_prog; m_pc = 0; m_done = 0;
                end
            end else if (s) begin
                if (!m_done && m_prog.size() > 0) begin
                    mcw = m_prog[m_pc]; mv = 1'b1; m_pc++;
                    if (m_pc == m_prog.size()) begin
                        m_pc = 0; m_done = 1;
                    end
                end
            end else if (l) begin
                if (!m_done) begin
                    if (m_prog.size() == DEPTH) m_ovf = 1;
                    else m_prog.push_back(d);
                end
            end
            pulse(c, r, s, l, d);
            chk($sformatf("rand%0d", it), 32'(snap()),
                32'(ex(mcw, mv, 3'(m_pc), 4'(m_prog.size()), (m_pend.size() > 0), m_done, m_ovf)));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
